// File: rtl/alu_nibble_seq_pkg.sv
// Shared definitions for the nibble-serial ALU sequencer: request op codes,
// ALU select encodings, FSM state encoding and small decode helpers.
`ifndef ALU_NIBBLE_SEQ_PKG_SV
`define ALU_NIBBLE_SEQ_PKG_SV

package alu_nibble_seq_pkg;

    // Wide operation requested by the client.
    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_ADC = 2'b01,
        OP_XOR = 2'b10,
        OP_MOV = 2'b11
    } op_e;

    // 4-bit ALU select codes used by this block.
    localparam logic [2:0] ALU_SEL_ADD  = 3'b011;
    localparam logic [2:0] ALU_SEL_XOR  = 3'b100;
    localparam logic [2:0] ALU_SEL_THRU = 3'b111;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // ALU select that implements one nibble of a wide op.
    function automatic logic [2:0] alu_sel_for(input op_e op);
        logic [2:0] sel;
        case (op)
            OP_ADD, OP_ADC: sel = ALU_SEL_ADD;
            OP_XOR:         sel = ALU_SEL_XOR;
            default:        sel = ALU_SEL_THRU;
        endcase
        return sel;
    endfunction

    // Only the arithmetic ops chain a carry between nibbles; the ALU adds
    // carry_in unconditionally, so the others must see carry_in = 0.
    function automatic logic op_chains_carry(input op_e op);
        return (op == OP_ADD) || (op == OP_ADC);
    endfunction

endpackage

`endif

// File: rtl/alu_nibble_seq_if.sv
// Request/response handshake bus plus the ALU-side signals of the
// nibble-serial sequencer. The slave modport is the sequencer itself; the
// master modport is the client that issues requests and takes responses.
interface alu_nibble_seq_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    // Request channel
    logic           req_valid;
    logic           req_ready;
    logic [1:0]     req_op;
    logic           req_carry;
    logic [W-1:0]   req_a;
    logic [W-1:0]   req_b;

    // Connection to the 4-bit ALU
    logic [2:0]     alu_sel;
    logic [3:0]     alu_a;
    logic [3:0]     alu_b;
    logic           alu_carry_in;
    logic [3:0]     alu_out;
    logic           alu_carry_out;

    // Response channel
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_result;
    logic           rsp_carry;
    logic           rsp_zero;

    modport master (
        output req_valid, req_op, req_carry, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero
    );

    modport slave (
        input  req_valid, req_op, req_carry, req_a, req_b, rsp_ready,
        input  alu_out, alu_carry_out,
        output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero,
        output alu_sel, alu_a, alu_b, alu_carry_in
    );

endinterface

// File: rtl/alu.sv
// 4-bit HC4e ALU, the subset of selects used by the nibble sequencer.
// Every listed function adds carry_in to its result; unlisted selects
// produce zero.
module alu
    import alu_nibble_seq_pkg::*;
(
    input  logic [2:0] sel_in,
    input  logic [3:0] in_A,
    input  logic [3:0] in_B,
    input  logic       carry_in,
    output logic [3:0] out,
    output logic       carry_out
);

    logic [4:0] w_sum;

    // Select the function and fold in carry_in.
    always_comb begin
        w_sum = 5'd0;
        case (sel_in)
            ALU_SEL_ADD:  w_sum = {1'b0, in_A} + {1'b0, in_B} + {4'd0, carry_in};
            ALU_SEL_XOR:  w_sum = {1'b0, in_A ^ in_B} + {4'd0, carry_in};
            ALU_SEL_THRU: w_sum = {1'b0, in_A} + {4'd0, carry_in};
            default:      w_sum = 5'd0;
        endcase
    end

    assign out       = w_sum[3:0];
    assign carry_out = w_sum[4];

endmodule

// File: rtl/alu_nibble_seq.sv
// Nibble-serial sequencer: runs a wide ADD/ADC/XOR/MOV through the external
// 4-bit ALU one nibble per clock, LS nibble first, chaining the carry and
// assembling the wide result. IDLE accepts a request, RUN walks the
// nibbles, DONE holds the response until it is taken.
module alu_nibble_seq
    import alu_nibble_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic              clock,
    input  logic              reset,
    alu_nibble_seq_if.slave   bus
);

    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_e                     r_state;
    state_e                     w_state_nxt;
    logic                       w_accept;

    logic [NIBBLES-1:0][3:0]    r_a;
    logic [NIBBLES-1:0][3:0]    r_b;
    op_e                        r_op;
    logic [NIBBLES-1:0][3:0]    r_result;
    logic                       r_carry;
    logic [IDX_W-1:0]           r_idx;

    logic                       w_run;
    logic                       w_last;

    assign w_run  = (r_state == ST_RUN);
    assign w_last = (r_idx == LAST_IDX);

    // State register; reset abandons any in-flight operation.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                bus.req_ready = !reset;
                if (bus.req_valid && !reset) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operand capture on accept; operands are only read during RUN, so
    // they need no reset.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_a  <= bus.req_a;
            r_b  <= bus.req_b;
            r_op <= op_e'(bus.req_op);
        end
    end

    // Result/carry/index: initialised on accept, updated once per RUN cycle
    // with the ALU's combinational answer for the current nibble.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_result <= '0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
        end else if (w_accept) begin
            r_result <= '0;
            r_carry  <= (op_e'(bus.req_op) == OP_ADC) ? bus.req_carry : 1'b0;
            r_idx    <= '0;
        end else if (w_run) begin
            r_result[r_idx] <= bus.alu_out;
            r_carry         <= op_chains_carry(r_op) ? bus.alu_carry_out : 1'b0;
            if (!w_last) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // ALU drive: current nibble during RUN, fixed pass-through of zero
    // otherwise (and while reset is held) so the ALU never sees X.
    always_comb begin
        bus.alu_sel      = ALU_SEL_THRU;
        bus.alu_a        = 4'h0;
        bus.alu_b        = 4'h0;
        bus.alu_carry_in = 1'b0;
        if (w_run && !reset) begin
            bus.alu_sel      = alu_sel_for(r_op);
            bus.alu_a        = r_a[r_idx];
            bus.alu_b        = (r_op == OP_MOV) ? 4'h0 : r_b[r_idx];
            bus.alu_carry_in = op_chains_carry(r_op) ? r_carry : 1'b0;
        end
    end

    // Response fields come straight from registered state.
    assign bus.rsp_result = r_result;
    assign bus.rsp_carry  = r_carry;
    assign bus.rsp_zero   = (r_result == '0);

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Bench for alu_nibble_seq wired to the real 4-bit ALU. Expected responses
// are computed from a wide reference model at issue time and queued; they
// are popped and compared when the response handshake happens.
module tb_alu_nibble_seq;
    import alu_nibble_seq_pkg::*;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    typedef struct packed {
        logic [W-1:0] result;
        logic         carry;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    alu_nibble_seq_if #(.NIBBLES(NIBBLES)) bus ();

    alu_nibble_seq #(.NIBBLES(NIBBLES)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    alu u_alu (
        .sel_in    (bus.alu_sel),
        .in_A      (bus.alu_a),
        .in_B      (bus.alu_b),
        .carry_in  (bus.alu_carry_in),
        .out       (bus.alu_out),
        .carry_out (bus.alu_carry_out)
    );

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wide reference: ADD/ADC are plain W-bit additions, XOR/MOV never carry.
    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic cin);
        exp_t e;
        logic [W:0] s;
        case (op)
            2'b00:   s = {1'b0, a} + {1'b0, b};
            2'b01:   s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            2'b10:   s = {1'b0, a ^ b};
            default: s = {1'b0, a};
        endcase
        e.result = s[W-1:0];
        e.carry  = s[W];
        return e;
    endfunction

    function automatic logic [2:0] exp_sel(input logic [1:0] op);
        case (op)
            2'b00, 2'b01: return 3'b011;
            2'b10:        return 3'b100;
            default:      return 3'b111;
        endcase
    endfunction

    task automatic check_alu_idle(input string tag);
        check({tag, "_alu_sel"}, bus.alu_sel, 3'b111);
        check({tag, "_alu_a"},   bus.alu_a, 4'h0);
        check({tag, "_alu_b"},   bus.alu_b, 4'h0);
        check({tag, "_alu_cin"}, bus.alu_carry_in, 1'b0);
    endtask

    // Offer a request and wait (bounded) until it is taken at a rising edge.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic cin);
        int n;
        @(negedge clock);
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_carry = cin;
        bus.req_valid = 1'b1;
        sb.push_back(model(op, a, b, cin));
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("req_ready_wait", bus.req_ready, 1'b1);
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
    endtask

    // Observe the NIBBLES RUN cycles after an accept, then the first DONE cycle.
    task automatic run_phase(input logic [1:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic cin);
        logic       c;
        logic [3:0] an, bn;
        logic [4:0] s;
        c = (op == 2'b01) ? cin : 1'b0;
        for (int k = 0; k < NIBBLES; k++) begin
            @(negedge clock);
            an = a[4*k +: 4];
            bn = b[4*k +: 4];
            check("run_sel",   bus.alu_sel, exp_sel(op));
            check("run_alu_a", bus.alu_a, an);
            check("run_alu_b", bus.alu_b, (op == 2'b11) ? 4'h0 : bn);
            check("run_cin",   bus.alu_carry_in, (op[1] == 1'b0) ? c : 1'b0);
            check("run_rsp_valid", bus.rsp_valid, 1'b0);
            s = {1'b0, an} + {1'b0, bn} + {4'd0, c};
            c = (op[1] == 1'b0) ? s[4] : 1'b0;
        end
        @(negedge clock);
        check("done_rsp_valid", bus.rsp_valid, 1'b1);
    endtask

    // Hold off the response for 'hold' cycles, then take it and compare.
    task automatic collect(input int hold);
        logic [W-1:0] snap;
        exp_t         e;
        snap = bus.rsp_result;
        for (int i = 0; i < hold; i++) begin
            check("bp_rsp_valid", bus.rsp_valid, 1'b1);
            check("bp_req_ready", bus.req_ready, 1'b0);
            check("bp_result_stable", bus.rsp_result, snap);
            @(negedge clock);
        end
        bus.rsp_ready = 1'b1;
        if (sb.size() == 0) begin
            check("sb_nonempty", 0, 1);
        end else begin
            e = sb.pop_front();
            check("rsp_valid",  bus.rsp_valid, 1'b1);
            check("rsp_result", bus.rsp_result, e.result);
            check("rsp_carry",  bus.rsp_carry, e.carry);
            check("rsp_zero",   bus.rsp_zero, (e.result == '0));
        end
        @(posedge clock);
        #1 bus.rsp_ready = 1'b0;
        @(negedge clock);
        check("idle_rsp_valid", bus.rsp_valid, 1'b0);
        check("idle_req_ready", bus.req_ready, 1'b1);
        if (!bus.req_valid) begin
            check_alu_idle("idle");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]   op;
        logic [W-1:0] a, b;
        logic         ci;

        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_carry = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_rsp_valid",  bus.rsp_valid, 1'b0);
        check("rst_rsp_result", bus.rsp_result, 16'h0);
        check("rst_rsp_carry",  bus.rsp_carry, 1'b0);
        check("rst_rsp_zero",   bus.rsp_zero, 1'b1);
        check("rst_req_ready",  bus.req_ready, 1'b0);
        check_alu_idle("rst");
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("post_rst_req_ready", bus.req_ready, 1'b1);
        check_alu_idle("post_rst");

        // ADD carry chain
        issue(2'b00, 16'h00FF, 16'h0001, 1'b0);
        run_phase(2'b00, 16'h00FF, 16'h0001, 1'b0);
        collect(0);

        // ADC wrap
        issue(2'b01, 16'hFFFF, 16'h0000, 1'b1);
        run_phase(2'b01, 16'hFFFF, 16'h0000, 1'b1);
        collect(0);

        // XOR
        issue(2'b10, 16'hA5A5, 16'hFFFF, 1'b1);
        run_phase(2'b10, 16'hA5A5, 16'hFFFF, 1'b1);
        collect(0);

        // MOV
        issue(2'b11, 16'h1234, 16'hFFFF, 1'b0);
        run_phase(2'b11, 16'h1234, 16'hFFFF, 1'b0);
        collect(0);

        // Backpressure with a queued request held on the request side
        issue(2'b00, 16'h1111, 16'h2222, 1'b0);
        run_phase(2'b00, 16'h1111, 16'h2222, 1'b0);
        bus.req_op    = 2'b10;
        bus.req_a     = 16'h3C3C;
        bus.req_b     = 16'h0FF0;
        bus.req_carry = 1'b0;
        bus.req_valid = 1'b1;
        sb.push_back(model(2'b10, 16'h3C3C, 16'h0FF0, 1'b0));
        collect(3);
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        run_phase(2'b10, 16'h3C3C, 16'h0FF0, 1'b0);
        collect(0);

        // Reset during RUN
        issue(2'b00, 16'h1234, 16'h4321, 1'b0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        sb = {};
        check("mid_rst_rsp_valid",  bus.rsp_valid, 1'b0);
        check("mid_rst_rsp_result", bus.rsp_result, 16'h0);
        check("mid_rst_rsp_zero",   bus.rsp_zero, 1'b1);
        check("mid_rst_req_ready",  bus.req_ready, 1'b0);
        check_alu_idle("mid_rst");
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("mid_rst_after_ready", bus.req_ready, 1'b1);
        check("mid_rst_after_valid", bus.rsp_valid, 1'b0);
        issue(2'b00, 16'h0F0F, 16'h0101, 1'b0);
        run_phase(2'b00, 16'h0F0F, 16'h0101, 1'b0);
        collect(0);

        // Mixed random operations
        for (int t = 0; t < 8; t++) begin
            op = 2'($urandom_range(0, 3));
            a  = 16'($urandom);
            b  = 16'($urandom);
            ci = 1'($urandom_range(0, 1));
            issue(op, a, b, ci);
            run_phase(op, a, b, ci);
            collect(int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
